// File: rtl/memcfg_nb_pkg.sv
// memcfg_nb_pkg: shared types and constants for the memcfg_nb page-to-frame
// configurator.
//   - state_t      : configuration FSM states
//   - map_entry_t  : one map RAM word {module, frame}
//   - PROT_*       : the two hard-wired boot entries (nb 0, pages 0/1)
//   - CMD_*        : strobe-time command decode levels of ad15/ad14
//   - fits_width() : range check of a 4-bit field against a narrower width
package memcfg_nb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2,
    ST_REJ   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] mod_num;
    logic [3:0] frame;
  } map_entry_t;

  // Boot entries: (nb 0, page 0) -> (module 0, frame 0), (nb 0, page 1) -> (module 0, frame 1)
  localparam int unsigned PROT_NB      = 32'd0;
  localparam int unsigned PROT_PAGE_LO = 32'd0;
  localparam int unsigned PROT_PAGE_HI = 32'd1;
  localparam logic [3:0]  PROT_MODULE  = 4'd0;
  localparam logic [3:0]  PROT_FRAME_LO = 4'd0;
  localparam logic [3:0]  PROT_FRAME_HI = 4'd1;

  // ad15 level that selects a memory-configuration command, ad14 level meaning unmap
  localparam logic CMD_CFG   = 1'b1;
  localparam logic CMD_UNMAP = 1'b1;

  // True when value has no bits set at or above bit position 'width'
  function automatic logic fits_width(input logic [3:0] value, input int unsigned width);
    return (value >> width) == 4'd0;
  endfunction

endpackage

// File: rtl/memcfg_nb_if.sv
// memcfg_nb_if: CPU-side bus of the memory configurator.
//   Configuration: s_ (strobe, active low), ad15/ad14 (command), cfg_nb,
//   cfg_page, cfg_module, cfg_frame -> cok (ack), cerr (nack).
//   Translation:   rd, nb, page -> module_num, frame, pvalid.
// The translated module output is called module_num because 'module' is a
// reserved word.
// Modports: master = CPU / memory-interface side, slave = memcfg_nb.
interface memcfg_nb_if #(
  parameter int NB_WIDTH   = 4,
  parameter int PAGE_WIDTH = 4
);
  logic                  s_;
  logic                  ad15;
  logic                  ad14;
  logic [NB_WIDTH-1:0]   cfg_nb;
  logic [PAGE_WIDTH-1:0] cfg_page;
  logic [3:0]            cfg_module;
  logic [3:0]            cfg_frame;
  logic                  rd;
  logic [NB_WIDTH-1:0]   nb;
  logic [PAGE_WIDTH-1:0] page;
  logic                  cok;
  logic                  cerr;
  logic [3:0]            module_num;
  logic [3:0]            frame;
  logic                  pvalid;

  modport master (
    output s_, ad15, ad14, cfg_nb, cfg_page, cfg_module, cfg_frame, rd, nb, page,
    input  cok, cerr, module_num, frame, pvalid
  );

  modport slave (
    input  s_, ad15, ad14, cfg_nb, cfg_page, cfg_module, cfg_frame, rd, nb, page,
    output cok, cerr, module_num, frame, pvalid
  );
endinterface

// File: rtl/memcfg_nb_map_ram.sv
// memcfg_nb_map_ram: synchronous single-port map RAM, write-first, no reset,
// written so that it infers block RAM.
//   clk   : clock
//   we    : write enable
//   addr  : word address ({nb, page} or the latched command address)
//   wdata : word to write
//   rdata : word at addr, registered (new data on a write)
module memcfg_nb_map_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [0:(1 << ADDR_WIDTH) - 1];

  // Single port: write-first so a read of the word being written sees the new value
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
      rdata       <= wdata;
    end else begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/memcfg_nb.sv
// memcfg_nb: page-to-frame memory configurator for multi-segment address spaces.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : memcfg_nb_if.slave (configuration strobe/command/operands, cok,
//           cerr; translation request rd/nb/page, module_num/frame/pvalid)
// Configuration macro: MEMCFG_NACK_EN -- when defined, a rejected command raises
// cerr from the cycle after entering REJ until s_ returns high; otherwise cerr
// stays 0 and the CPU times out. FSM timing is the same in both builds.
// Translation has one cycle of latency. Operands are latched when the strobe is
// seen in IDLE; later operand changes while s_ stays low are ignored.
module memcfg_nb
  import memcfg_nb_pkg::*;
#(
  parameter int NB_WIDTH          = 4,
  parameter int PAGE_WIDTH        = 4,
  parameter int MODULE_ADDR_WIDTH = 4,
  parameter int FRAME_ADDR_WIDTH  = 4
) (
  input logic         clk,
  input logic         reset,
  memcfg_nb_if.slave  bus
);

  localparam int ADDR_WIDTH = NB_WIDTH + PAGE_WIDTH;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  state_t                state_r, state_s;
  logic                  cok_r, cok_s;
  logic                  cerr_r, cerr_s;
  logic [ADDR_WIDTH-1:0] cmd_addr_r;
  map_entry_t            cmd_entry_r;
  logic                  cmd_unmap_r;
  logic [DEPTH-1:0]      valid_r;

  logic                  cfg_prot_s, acc_prot_s, cfg_unmap_s, cfg_range_ok_s;
  logic                  cmd_ours_s, cmd_valid_s, req_s;
  logic [ADDR_WIDTH-1:0] acc_addr_s, ram_addr_s;
  logic                  ram_we_s;
  logic [7:0]            ram_rdata_s;
  map_entry_t            ram_entry_s;
  logic                  hit_s, from_ram_s;
  logic [3:0]            prot_frame_s;
  logic                  pvalid_r, from_ram_r;
  logic [3:0]            prot_frame_r;

  assign cfg_prot_s  = (bus.cfg_nb == NB_WIDTH'(PROT_NB)) &&
                       ((bus.cfg_page == PAGE_WIDTH'(PROT_PAGE_LO)) ||
                        (bus.cfg_page == PAGE_WIDTH'(PROT_PAGE_HI)));
  assign acc_prot_s  = (bus.nb == NB_WIDTH'(PROT_NB)) &&
                       ((bus.page == PAGE_WIDTH'(PROT_PAGE_LO)) ||
                        (bus.page == PAGE_WIDTH'(PROT_PAGE_HI)));
  assign cfg_unmap_s    = (bus.ad14 == CMD_UNMAP);
  // Unmap ignores module/frame, so the range check only gates map commands
  assign cfg_range_ok_s = fits_width(bus.cfg_module, MODULE_ADDR_WIDTH) &&
                          fits_width(bus.cfg_frame, FRAME_ADDR_WIDTH);
  assign cmd_ours_s  = !bus.s_ && (bus.ad15 == CMD_CFG);
  assign cmd_valid_s = cmd_ours_s && !cfg_prot_s && (cfg_unmap_s || cfg_range_ok_s);
  assign req_s       = bus.rd && bus.s_;
  assign acc_addr_s  = {bus.nb, bus.page};

  // The single RAM port belongs to the pending write during WRITE
  assign ram_we_s   = (state_r == ST_WRITE) && !cmd_unmap_r;
  assign ram_addr_s = (state_r == ST_WRITE) ? cmd_addr_r : acc_addr_s;

  memcfg_nb_map_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (8)
  ) u_map_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (cmd_entry_r),
    .rdata (ram_rdata_s)
  );

  assign ram_entry_s = map_entry_t'(ram_rdata_s);

  // FSM next state and next cok/cerr
  always_comb begin
    state_s = state_r;
    cok_s   = 1'b0;
    cerr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid_s) begin
          state_s = ST_WRITE;
        end else if (cmd_ours_s) begin
          state_s = ST_REJ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_s = ST_ACK;
        cok_s   = 1'b1;
      end
      ST_ACK: begin
        if (bus.s_) begin
          state_s = ST_IDLE;
          cok_s   = 1'b0;
        end else begin
          state_s = ST_ACK;
          cok_s   = 1'b1;
        end
      end
      ST_REJ: begin
        if (bus.s_) begin
          state_s = ST_IDLE;
          cerr_s  = 1'b0;
        end else begin
          state_s = ST_REJ;
`ifdef MEMCFG_NACK_EN
          cerr_s  = 1'b1;
`else
          cerr_s  = 1'b0;
`endif
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and handshake output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cok_r   <= 1'b0;
      cerr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cok_r   <= cok_s;
      cerr_r  <= cerr_s;
    end
  end

  // Command operand latch, loaded only when the strobe is seen in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_addr_r  <= {ADDR_WIDTH{1'b0}};
      cmd_entry_r <= 8'd0;
      cmd_unmap_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && !bus.s_) begin
      cmd_addr_r  <= {bus.cfg_nb, bus.cfg_page};
      cmd_entry_r <= '{mod_num: bus.cfg_module, frame: bus.cfg_frame};
      cmd_unmap_r <= cfg_unmap_s;
    end
  end

  // Valid bits; reset wins over a write in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {DEPTH{1'b0}};
    end else if (state_r == ST_WRITE) begin
      valid_r[cmd_addr_r] <= !cmd_unmap_r;
    end
  end

  // Translation hit decode. A request sampled at the WRITE edge for the entry
  // being written sees the new mapping (RAM is write-first). A request for any
  // other entry at that edge can only happen after a one-cycle strobe and is
  // answered as a miss, since the single port is busy with the write.
  always_comb begin
    hit_s        = 1'b0;
    from_ram_s   = 1'b0;
    prot_frame_s = 4'd0;
    if (!req_s) begin
      hit_s      = 1'b0;
      from_ram_s = 1'b0;
    end else if (acc_prot_s) begin
      hit_s        = 1'b1;
      prot_frame_s = (bus.page == PAGE_WIDTH'(PROT_PAGE_HI)) ? PROT_FRAME_HI : PROT_FRAME_LO;
    end else if (state_r == ST_WRITE) begin
      if (acc_addr_s == cmd_addr_r) begin
        hit_s      = !cmd_unmap_r;
        from_ram_s = !cmd_unmap_r;
      end else begin
        hit_s      = 1'b0;
        from_ram_s = 1'b0;
      end
    end else begin
      hit_s      = valid_r[acc_addr_s];
      from_ram_s = valid_r[acc_addr_s];
    end
  end

  // Translation result registers, aligned with the RAM read data
  always_ff @(posedge clk) begin
    if (reset) begin
      pvalid_r     <= 1'b0;
      from_ram_r   <= 1'b0;
      prot_frame_r <= 4'd0;
    end else begin
      pvalid_r     <= hit_s;
      from_ram_r   <= from_ram_s;
      prot_frame_r <= prot_frame_s;
    end
  end

  assign bus.cok        = cok_r;
  assign bus.cerr       = cerr_r;
  assign bus.pvalid     = pvalid_r;
  assign bus.module_num = from_ram_r ? ram_entry_s.mod_num :
                          (pvalid_r ? PROT_MODULE : 4'd0);
  assign bus.frame      = from_ram_r ? ram_entry_s.frame : prot_frame_r;

endmodule

// File: tb/tb_memcfg_nb.sv
module tb_memcfg_nb;

  localparam int NBW = 4;
  localparam int PW  = 4;
  localparam int MW  = 4;
  localparam int FW  = 3;

`ifdef MEMCFG_NACK_EN
  localparam logic NACK = 1'b1;
`else
  localparam logic NACK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  memcfg_nb_if #(.NB_WIDTH(NBW), .PAGE_WIDTH(PW)) bus ();

  memcfg_nb #(
    .NB_WIDTH          (NBW),
    .PAGE_WIDTH        (PW),
    .MODULE_ADDR_WIDTH (MW),
    .FRAME_ADDR_WIDTH  (FW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference map: what each (nb, page) must translate to
  bit         m_valid [256];
  logic [3:0] m_mod   [256];
  logic [3:0] m_frame [256];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {pvalid, module, frame} for an address; boot entries are fixed
  function automatic logic [8:0] model_lookup(input int a);
    if (a < 2) return {1'b1, 4'd0, 4'(a)};
    else if (m_valid[a]) return {1'b1, m_mod[a], m_frame[a]};
    else return 9'd0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  // Every cycle: expectation from inputs at the edge, compared 2 time units later
  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(posedge clk);
      if (reset || !bus.rd || !bus.s_) e = 9'd0;
      else e = model_lookup(int'({bus.nb, bus.page}));
      #2;
      chk("mon_pvalid", {3'd0, bus.pvalid}, {3'd0, e[8]});
      chk("mon_module", bus.module_num, e[7:4]);
      chk("mon_frame", bus.frame, e[3:0]);
    end
  endtask

  task automatic rd_expect(input int n, input int p, input logic pv, input logic [3:0] m,
                           input logic [3:0] f);
    @(negedge clk);
    bus.rd = 1'b1; bus.nb = 4'(n); bus.page = 4'(p);
    @(negedge clk);
    chk("rd_pvalid", {3'd0, bus.pvalid}, {3'd0, pv});
    chk("rd_module", bus.module_num, m);
    chk("rd_frame", bus.frame, f);
    bus.rd = 1'b0;
  endtask

  task automatic cmd(input logic unmap, input int n, input int p, input logic [3:0] cm,
                     input logic [3:0] cf, input logic ok, input int hold);
    int a;
    @(negedge clk);
    bus.ad15 = 1'b1; bus.ad14 = unmap;
    bus.cfg_nb = 4'(n); bus.cfg_page = 4'(p); bus.cfg_module = cm; bus.cfg_frame = cf;
    bus.s_ = 1'b0;
    a = n * 16 + p;
    if (ok) begin
      if (unmap) m_valid[a] = 1'b0;
      else begin m_valid[a] = 1'b1; m_mod[a] = cm; m_frame[a] = cf; end
    end
    @(negedge clk);
    chk("cok_early", {3'd0, bus.cok}, 4'd0);
    @(negedge clk);
    chk("cok_rise", {3'd0, bus.cok}, {3'd0, ok});
    chk("cerr_rise", {3'd0, bus.cerr}, {3'd0, !ok && NACK});
    // Operand changes while the strobe stays low must not matter
    bus.cfg_page = 4'(p ^ 1); bus.cfg_module = ~cm; bus.cfg_frame = ~cf;
    repeat (hold) @(negedge clk);
    chk("cok_hold", {3'd0, bus.cok}, {3'd0, ok});
    chk("cerr_hold", {3'd0, bus.cerr}, {3'd0, !ok && NACK});
    bus.s_ = 1'b1; bus.ad15 = 1'b0;
    @(negedge clk);
    chk("cok_fall", {3'd0, bus.cok}, 4'd0);
    chk("cerr_fall", {3'd0, bus.cerr}, 4'd0);
  endtask

  initial begin
    bus.s_ = 1'b1; bus.ad15 = 1'b0; bus.ad14 = 1'b0;
    bus.cfg_nb = 4'd0; bus.cfg_page = 4'd0; bus.cfg_module = 4'd0; bus.cfg_frame = 4'd0;
    bus.rd = 1'b0; bus.nb = 4'd0; bus.page = 4'd0;
    model_clear();
    for (int i = 0; i < 256; i++) begin m_mod[i] = 4'd0; m_frame[i] = 4'd0; end

    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cok", {3'd0, bus.cok}, 4'd0);
    chk("rst_cerr", {3'd0, bus.cerr}, 4'd0);
    chk("rst_pvalid", {3'd0, bus.pvalid}, 4'd0);
    chk("rst_module", bus.module_num, 4'd0);
    chk("rst_frame", bus.frame, 4'd0);
    reset = 1'b0;

    // Boot entries and an unmapped entry
    rd_expect(0, 1, 1'b1, 4'd0, 4'd1);
    rd_expect(0, 2, 1'b0, 4'd0, 4'd0);
    rd_expect(0, 0, 1'b1, 4'd0, 4'd0);

    // Map then unmap
    cmd(1'b0, 3, 5, 4'd2, 4'd7, 1'b1, 2);
    rd_expect(3, 5, 1'b1, 4'd2, 4'd7);
    cmd(1'b1, 3, 5, 4'd0, 4'd0, 1'b1, 1);
    rd_expect(3, 5, 1'b0, 4'd0, 4'd0);

    // Rejections: protected map, protected unmap, frame out of range
    cmd(1'b0, 0, 1, 4'd3, 4'd3, 1'b0, 2);
    rd_expect(0, 1, 1'b1, 4'd0, 4'd1);
    cmd(1'b1, 0, 0, 4'd0, 4'd0, 1'b0, 0);
    rd_expect(0, 0, 1'b1, 4'd0, 4'd0);
    cmd(1'b0, 2, 2, 4'd1, 4'd8, 1'b0, 1);
    rd_expect(2, 2, 1'b0, 4'd0, 4'd0);

    // Unmap of an invalid entry is acknowledged; frame range not checked
    cmd(1'b1, 2, 2, 4'd0, 4'd8, 1'b1, 0);
    rd_expect(2, 2, 1'b0, 4'd0, 4'd0);

    // Reset during WRITE
    cmd(1'b0, 1, 0, 4'd5, 4'd2, 1'b1, 0);
    cmd(1'b0, 4, 4, 4'd1, 4'd1, 1'b1, 0);
    rd_expect(1, 0, 1'b1, 4'd5, 4'd2);
    @(negedge clk);
    bus.ad15 = 1'b1; bus.ad14 = 1'b0; bus.cfg_nb = 4'd1; bus.cfg_page = 4'd0;
    bus.cfg_module = 4'd6; bus.cfg_frame = 4'd3; bus.s_ = 1'b0;
    @(negedge clk);
    reset = 1'b1; bus.s_ = 1'b1; bus.ad15 = 1'b0;
    model_clear();
    @(negedge clk);
    chk("midrst_cok", {3'd0, bus.cok}, 4'd0);
    chk("midrst_cerr", {3'd0, bus.cerr}, 4'd0);
    reset = 1'b0;
    rd_expect(1, 0, 1'b0, 4'd0, 4'd0);
    rd_expect(4, 4, 1'b0, 4'd0, 4'd0);
    rd_expect(0, 1, 1'b1, 4'd0, 4'd1);

    // Back-to-back commands, then overwrite of a valid entry
    cmd(1'b0, 7, 9, 4'd3, 4'd6, 1'b1, 0);
    cmd(1'b0, 7, 10, 4'd1, 4'd2, 1'b1, 0);
    rd_expect(7, 9, 1'b1, 4'd3, 4'd6);
    rd_expect(7, 10, 1'b1, 4'd1, 4'd2);
    cmd(1'b0, 7, 9, 4'd9, 4'd5, 1'b1, 1);
    rd_expect(7, 9, 1'b1, 4'd9, 4'd5);

    // Strobe with ad15=0 is not ours; a read under s_ low returns nothing
    @(negedge clk);
    bus.ad15 = 1'b0; bus.ad14 = 1'b0; bus.cfg_nb = 4'd7; bus.cfg_page = 4'd9;
    bus.cfg_module = 4'd2; bus.cfg_frame = 4'd2; bus.s_ = 1'b0;
    bus.rd = 1'b1; bus.nb = 4'd7; bus.page = 4'd9;
    repeat (3) begin
      @(negedge clk);
      chk("foreign_cok", {3'd0, bus.cok}, 4'd0);
      chk("foreign_cerr", {3'd0, bus.cerr}, 4'd0);
      chk("slow_pvalid", {3'd0, bus.pvalid}, 4'd0);
    end
    bus.s_ = 1'b1; bus.rd = 1'b0;
    rd_expect(7, 9, 1'b1, 4'd9, 4'd5);

    // Sweep of reads checked by the monitor
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.rd = (i % 5) != 3;
      bus.nb = 4'((i * 7) % 8);
      bus.page = 4'((i * 3) % 11);
    end
    @(negedge clk);
    bus.rd = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memcfg_nb.md
Name: memcfg_nb

Overview:
- Parametrised page-to-frame memory configurator for multi-segment (NB) address spaces; successor to the single-segment 8-bit-page mapper.
- Sits between the CPU memory-interface strobes and the physical memory modules.
- Accepts "OU" configuration commands that map or unmap (nb, page) to (module, frame).
- Translates (nb, page) to (module, frame, valid) for every memory access.

Parameters:
- NB_WIDTH, 4, segment (NB) number width.
- PAGE_WIDTH, 4, page-within-segment width; map depth = 2**(NB_WIDTH+PAGE_WIDTH).
- MODULE_ADDR_WIDTH, 4, module number width (1..4).
- FRAME_ADDR_WIDTH, 4, frame-within-module width (1..4; 3 for 32K modules).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- s_  in  1  configuration strobe, active low.
- ad15  in  1  command select: 1 = memory-configuration command.
- ad14  in  1  with ad15: 0 = map, 1 = unmap.
- cfg_nb  in  NB_WIDTH  segment being configured.
- cfg_page  in  PAGE_WIDTH  page being configured.
- cfg_module  in  4  target module (from rdt).
- cfg_frame  in  4  target frame (from rdt).
- rd  in  1  translation request enable.
- nb  in  NB_WIDTH  access segment.
- page  in  PAGE_WIDTH  access page.
- cok  out  1  configuration acknowledge.
- cerr  out  1  configuration rejected (optional feature).
- module  out  4  translated module; 0 when not valid.
- frame  out  4  translated frame; 0 when not valid.
- pvalid  out  1  translation hit.

Behaviour:
- Reset (synchronous, one cycle, wins over everything):
  - cok=0, cerr=0, pvalid=0, module=0, frame=0, state=IDLE.
  - All valid bits cleared except protected entries.
  - Map RAM contents are not reset.
- Protected entries: (nb=0, page=0) -> (module 0, frame 0) and (nb=0, page=1) -> (module 0, frame 1).
  - Hard-wired valid; never writable, never unmappable.
- Address select: (cfg_nb, cfg_page) when s_=0, otherwise (nb, page).
- Translation:
  - Registered, latency 1: outputs in cycle N+1 reflect rd/nb/page sampled at edge N.
  - rd=0 or s_=0 at the sample edge -> pvalid=0, module=0, frame=0 in N+1.
  - Invalid entry -> pvalid=0, module=frame=0.
- Command validity: ~s_ & ad15 & (cfg_nb,cfg_page) not protected & cfg_module has no bits above MODULE_ADDR_WIDTH & cfg_frame has no bits above FRAME_ADDR_WIDTH.
  - Module/frame range check applies to map commands only; unmap ignores module/frame.
- FSM, states IDLE, WRITE, ACK, REJ:
  - IDLE: valid command -> WRITE. ~s_ & ad15 & invalid -> REJ. ~s_ & ~ad15 -> stay IDLE (not ours).
  - WRITE, one cycle:
    - map: RAM[addr] <= {module, frame}; valid[addr] <= 1.
    - unmap: valid[addr] <= 0.
    - Go to ACK with cok <= 1, so cok rises 2 cycles after the strobe edge.
  - ACK: hold cok=1 until s_=1, then cok <= 0 and go to IDLE.
  - REJ: cok stays 0; wait for s_=1, then go to IDLE.
- Inputs are sampled only in IDLE. Operand changes while s_ stays low are ignored.
- A strobe shorter than 1 cycle is missed; no acknowledge is given.
- Read-after-write: a translation sampled on or after the WRITE edge returns the new mapping.
- Re-mapping an already valid entry overwrites it.
- Unmapping an invalid entry still gives cok.
- Reset while in WRITE: the write may be lost; valid is cleared (reset wins). FSM goes to IDLE, cok=0.

Optional Feature:
- Macro: MEMCFG_NACK_EN.
- Defined: REJ drives cerr=1 from the cycle after entering REJ until s_=1. The CPU gets an immediate negative answer.
- Undefined: cerr tied 0; a rejected command is silently ignored and the CPU relies on its no-answer timeout. FSM timing is identical in both builds.

Decomposition:
- memcfg_pkg:
  - FSM state enum.
  - Map entry struct {module[3:0], frame[3:0]}.
  - Protected-entry constants: nb 0, pages 0/1 -> frames 0/1.
  - Command decode constants (ad15 = cfg, ad14 = unmap).
- Sub-module memcfg_map_ram:
  - Synchronous single-port 8-bit-wide RAM, depth 2**(NB_WIDTH+PAGE_WIDTH), inferrable to block RAM.
  - The valid-bit vector stays in flops in the top level.

Test Plan:
- Reset, then rd=1 nb=0 page=1 -> next cycle pvalid=1, module=0, frame=1. nb=0 page=2 -> pvalid=0, frame=0.
- Map: s_=0 ad15=1 ad14=0 cfg_nb=3 cfg_page=5 module=2 frame=7 -> cok=1 two cycles later, held until s_=1. Then read nb=3 page=5 -> pvalid=1, module=2, frame=7.
- Unmap nb=3 page=5 -> cok=1. Read nb=3 page=5 -> pvalid=0, module=0, frame=0.
- Protected/range rejection: map nb=0 page=1, or FRAME_ADDR_WIDTH=3 with frame=8 -> cok never 1. cerr=1 with MEMCFG_NACK_EN, cerr=0 without. Entry unchanged.
- Reset mid-command: assert reset in the WRITE cycle of a map to nb=1 page=0 -> cok=0, state IDLE, read nb=1 page=0 -> pvalid=0.
- Back-to-back: two map commands separated by one s_=1 cycle -> both acknowledged. ad15=0 strobe -> no cok, map unchanged.
